cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Arbitrates the cache-side memory bus (cbus) between several cache masters, for example the instruction cache and the data cache, onto the single cbus port toward memory. It sits directly downstream of the data cache's `creq`/`cresp` port. Once a master is granted a burst, the arbiter locks onto it until the final beat (`ready && last`), then re-arbitrates. Losing masters see an all-zero response while they wait.

## Interface
- `NUM_INPUTS`, default 2: number of cbus masters; index 0 is the data cache, index 1 is the instruction cache.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ireqs` in `cbus_req_t[NUM_INPUTS]`: master requests. Each request carries `valid`, `is_write`, `size`, `addr`, `strobe`, `data` and `len`.
- `iresps` out `cbus_resp_t[NUM_INPUTS]`: per-master responses. Each response carries `ready`, `last` and `data`.
- `oreq` out `cbus_req_t`: request forwarded to memory.
- `oresp` in `cbus_resp_t`: response from memory.

## Operation
- Registers:
  - `busy`: 1 bit.
  - `index`: `$clog2(NUM_INPUTS)` bits.
  - `last_grant`: same width as `index`; only present when `CBUS_ARB_RR_EN` is defined.
- States are IDLE (`busy=0`) and BUSY (`busy=1`).
- IDLE:
  - If any `ireqs[i].valid` is set, pick the winner `w` by the priority rule (see Configuration).
  - Next state is BUSY with `index<=w`.
  - With no valid request, stay in IDLE.
- BUSY:
  - `oreq = ireqs[index]`, passed through combinationally. The arbiter does not latch a copy of the request.
  - `iresps[index] = oresp`. Every other `iresps[j]` is all-zero.
  - When `oresp.ready && oresp.last`, go to IDLE next cycle.
  - If `ireqs[index].valid==0` while in BUSY (protocol violation / abort), go to IDLE next cycle. The response for that cycle is still routed to `index`.
- In IDLE, `oreq` and all `iresps` are all-zero. Memory never sees a request that has not been granted.
- A new request arriving during BUSY waits; it gets no `ready`.
- Simultaneous valid requests: exactly one wins; the others stay pending and are served in later arbitration rounds.
- Masters must hold their request fields stable until they see their own `ready && last`.

## Timing
- Reset values: `busy=0`, `index=0`, `last_grant=NUM_INPUTS-1`. Consequently `oreq=0` and `iresps=0` in the cycle after reset is sampled.
- Grant latency:
  - Request first valid in cycle t.
  - Arbitration is registered at the end of t.
  - `oreq.valid=1` from cycle t+1.
- End of burst:
  - `ready && last` in cycle t puts the arbiter in IDLE in t+1.
  - The earliest next grant appears on `oreq` in t+2. There is always at least one idle bus cycle between bursts.
- No combinational path exists from `ireqs[*].valid` to the grant decision in the same cycle. `oreq` depends combinationally on `ireqs[index]` only while in BUSY.
- Reset asserted mid-burst: the arbiter is in IDLE and drives zero outputs next cycle. Any in-flight memory burst is abandoned (memory is reset together with the arbiter).
- `oresp` beats with `ready=0` are stalls and do not change state.

## Configuration
- `CBUS_ARB_RR_EN` defined: round-robin priority.
  - The search starts at `(last_grant+1) mod NUM_INPUTS` and takes the first valid request.
  - `last_grant<=w` on every grant.
- `CBUS_ARB_RR_EN` undefined: fixed priority, lowest valid index wins. The `last_grant` register is absent, and a continuously requesting master 0 can starve the others.

## Test plan
- Single master, reset released:
  - Stimulus: `ireqs[1]` reads `addr=0x1000`, `len=MLEN16`; memory answers 16 beats with `ready` every other cycle.
  - Required: `oreq==ireqs[1]` from cycle t+1; `iresps[1]` receives all 16 beats; `iresps[0]` stays 0; IDLE the cycle after `last`.
- Simultaneous requests:
  - Stimulus: both masters valid in the same cycle; each burst is 4 beats.
  - Required without `CBUS_ARB_RR_EN`: master 0, then master 1.
  - Required with `CBUS_ARB_RR_EN` from reset: master 0, then master 1. Repeating the pair then alternates 0,1,0,1.
- Round-robin fairness:
  - Stimulus: master 0 requests continuously; master 1 requests once.
  - Required with `CBUS_ARB_RR_EN`: master 1 is granted at the very next arbitration.
  - Required without it: master 1 waits until master 0 drops `valid`.
- Back-to-back gap:
  - Stimulus: `last` in cycle 10 with master 1 already pending.
  - Required: `oreq.valid==0` in cycle 11; master 1 appears on `oreq` in cycle 12.
- Reset mid-burst:
  - Stimulus: `reset=1` at beat 3 of 8.
  - Required: next cycle `oreq==0`, `iresps==0`, `busy==0`; after reset, a new request is granted normally.
- Abort:
  - Stimulus: the granted master drops `valid` at beat 2.
  - Required: IDLE next cycle; a pending other master is granted on `oreq` one cycle later.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// ============================================================================
// Module  : cbus_pkg / cbus_arbiter_if
// Brief   : cbus request/response types and the arbiter bus bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'h0;
  localparam logic [3:0] MLEN4  = 4'h3;
  localparam logic [3:0] MLEN16 = 4'hF;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  cbus_pkg::cbus_req_t  [NUM_INPUTS-1:0] ireqs;
  cbus_pkg::cbus_resp_t [NUM_INPUTS-1:0] iresps;
  cbus_pkg::cbus_req_t                   oreq;
  cbus_pkg::cbus_resp_t                  oresp;

  // slave: the arbiter; master: cache masters plus memory seen from outside
  modport slave  (input ireqs, input oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input iresps, input oreq);
endinterface

`default_nettype wire

// File: rtl/cbus_arbiter.sv
// ============================================================================
// Module  : cbus_arbiter
// Brief   : Burst-locked cbus arbiter; define CBUS_ARB_RR_EN for round-robin,
//           otherwise fixed priority (lowest index wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cbus_arbiter #(
  parameter int NUM_INPUTS = 2
) (
  input  logic           clk,
  input  logic           reset,
  cbus_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_next;
  logic [IDX_W-1:0] winner;
  logic             any_valid;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the slot right after last_grant wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_INPUTS);
      if (bus.ireqs[cand].valid) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_INPUTS - 1);
    end else if (state == IDLE && any_valid) begin
      last_grant <= winner;
    end
  end
`else
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (bus.ireqs[IDX_W'(i)].valid) begin
        winner    = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // The granted request is passed through, never latched; a dropped valid ends the lock.
  always_comb begin
    state_next = state;
    index_next = index;
    bus.oreq   = '0;
    bus.iresps = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = BUSY;
          index_next = winner;
        end
      end
      BUSY: begin
        bus.oreq          = bus.ireqs[index];
        bus.iresps[index] = bus.oresp;
        if ((bus.oresp.ready && bus.oresp.last) || !bus.ireqs[index].valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// ============================================================================
// Module  : tb_cbus_arbiter
// Brief   : Directed, table-driven bench for cbus_arbiter (both priority modes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;
  localparam logic [1:0] G_N = 2'd0;
  localparam logic [1:0] G_0 = 2'd1;
  localparam logic [1:0] G_1 = 2'd2;
  localparam logic [63:0] A0 = 64'h0000_0000_8000_A000;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_1000;
  localparam int NV = 33;

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic       v1;
    logic       rdy;
    logic       lst;
    logic [1:0] gnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_INPUTS(N)) bus ();
  cbus_arbiter #(.NUM_INPUTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  cbus_req_t  cur0, cur1;
  cbus_resp_t cur_resp;
  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic a, logic b, logic rd, logic l, logic [1:0] g);
    vec_t t;
    t.rst = r; t.v0 = a; t.v1 = b; t.rdy = rd; t.lst = l; t.gnt = g;
    return t;
  endfunction

  task automatic apply();
    bus.ireqs[0] = cur0;
    bus.ireqs[1] = cur1;
    bus.oresp    = cur_resp;
  endtask

  task automatic cmp(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected outputs come from the bench's own copies of what it drives.
  task automatic check_outputs(string tag, logic [1:0] g);
    cbus_req_t  e_req;
    cbus_resp_t e0, e1;
    e_req = '0; e0 = '0; e1 = '0;
    if (g == G_0) begin e_req = cur0; e0 = cur_resp; end
    if (g == G_1) begin e_req = cur1; e1 = cur_resp; end
    cmp({tag, " oreq"},      160'(bus.oreq),      160'(e_req));
    cmp({tag, " iresps[0]"}, 160'(bus.iresps[0]), 160'(e0));
    cmp({tag, " iresps[1]"}, 160'(bus.iresps[1]), 160'(e1));
  endtask

  initial begin
    int beats, bursts, m1_pos, m0_done, beat, exp_m1_pos;
    logic v0, v1;

    cur0 = '{valid: 1'b0, is_write: 1'b1, size: 3'd3, addr: A0, strobe: 8'hFF,
             data: 64'hDEAD_BEEF_0000_0001, len: MLEN4};
    cur1 = '{valid: 1'b0, is_write: 1'b0, size: 3'd3, addr: A1, strobe: 8'h00,
             data: 64'h0, len: MLEN16};
    cur_resp = '0;
    reset = 1'b1;
    apply();

    //               rst v0 v1 rdy lst gnt
    vecs[0]  = mk(1, 0, 0, 0, 0, G_N);
    vecs[1]  = mk(0, 1, 1, 0, 0, G_N);  // simultaneous: 0 first
    vecs[2]  = mk(0, 1, 1, 1, 0, G_0);
    vecs[3]  = mk(0, 1, 1, 0, 0, G_0);  // stall
    vecs[4]  = mk(0, 1, 1, 1, 0, G_0);
    vecs[5]  = mk(0, 1, 1, 1, 0, G_0);
    vecs[6]  = mk(0, 1, 1, 1, 1, G_0);
    vecs[7]  = mk(0, 0, 1, 0, 0, G_N);
    vecs[8]  = mk(0, 0, 1, 1, 0, G_1);
    vecs[9]  = mk(0, 0, 1, 1, 0, G_1);
    vecs[10] = mk(0, 0, 1, 1, 0, G_1);
    vecs[11] = mk(0, 0, 1, 1, 1, G_1);
    vecs[12] = mk(0, 0, 0, 0, 0, G_N);
    vecs[13] = mk(0, 1, 0, 0, 0, G_N);  // back-to-back gap
    vecs[14] = mk(0, 1, 1, 1, 0, G_0);
    vecs[15] = mk(0, 1, 1, 1, 1, G_0);
    vecs[16] = mk(0, 0, 1, 0, 0, G_N);
    vecs[17] = mk(0, 0, 1, 1, 1, G_1);
    vecs[18] = mk(0, 0, 0, 0, 0, G_N);
    vecs[19] = mk(0, 1, 0, 0, 0, G_N);  // abort at beat 2
    vecs[20] = mk(0, 1, 1, 1, 0, G_0);
    vecs[21] = mk(0, 0, 1, 1, 0, G_0);
    vecs[22] = mk(0, 0, 1, 0, 0, G_N);
    vecs[23] = mk(0, 0, 1, 1, 1, G_1);
    vecs[24] = mk(0, 0, 0, 0, 0, G_N);
    vecs[25] = mk(0, 0, 1, 0, 0, G_N);  // reset at beat 3
    vecs[26] = mk(0, 0, 1, 1, 0, G_1);
    vecs[27] = mk(0, 0, 1, 1, 0, G_1);
    vecs[28] = mk(1, 0, 1, 1, 0, G_1);
    vecs[29] = mk(0, 0, 0, 0, 0, G_N);
    vecs[30] = mk(0, 1, 0, 0, 0, G_N);
    vecs[31] = mk(0, 1, 0, 1, 1, G_0);
    vecs[32] = mk(0, 0, 0, 0, 0, G_N);

    repeat (3) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      cur0.valid  = vecs[i].v0;
      cur1.valid  = vecs[i].v1;
      cur_resp    = '{ready: vecs[i].rdy, last: vecs[i].lst, data: 64'h100 + 64'(i)};
      apply();
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].gnt);
    end

    // Master 0 keeps requesting 4 two-beat bursts; master 1 asks once.
    v0 = 1'b1; v1 = 1'b0; m0_done = 0; m1_pos = -1; bursts = 0; beat = 0;
    for (int c = 0; c < 80 && (v0 || v1 || c < 2); c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b1;
      cur0.valid = v0;
      cur1.valid = v1;
      cur_resp   = '0;
      apply();
      #1;
      if (bus.oreq.valid) begin
        if (beat == 0) begin
          bursts++;
          if (bus.oreq.addr == A1) m1_pos = bursts;
        end
        cur_resp = '{ready: 1'b1, last: (beat == 1), data: 64'(c)};
        apply();
        #1;
        if (beat == 1) begin
          beat = 0;
          if (bus.oreq.addr == A0) begin
            m0_done++;
            if (m0_done == 4) v0 = 1'b0;
          end else begin
            v1 = 1'b0;
          end
        end else begin
          beat = 1;
        end
      end
    end
`ifdef CBUS_ARB_RR_EN
    exp_m1_pos = 2;
`else
    exp_m1_pos = 5;
`endif
    cmp("fair m1 burst position", 160'(m1_pos), 160'(exp_m1_pos));
    cmp("fair total bursts", 160'(bursts), 160'(5));
    cmp("fair completed in budget", 160'({v0, v1}), 160'(2'b00));

    // Single master: 16-beat read, memory ready every other cycle.
    @(negedge clk);
    cur0.valid = 1'b0;
    cur1.valid = 1'b1;
    cur_resp   = '0;
    apply();
    #1;
    check_outputs("single k0", G_N);
    beats = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      cur_resp = '{ready: (k % 2 == 0), last: (k == 32), data: 64'h5000 + 64'(k)};
      apply();
      #1;
      check_outputs($sformatf("single k%0d", k), G_1);
      if (bus.iresps[1].ready) beats++;
    end
    @(negedge clk);
    cur1.valid = 1'b0;
    cur_resp   = '0;
    apply();
    #1;
    check_outputs("single after last", G_N);
    cmp("single beat count", 160'(beats), 160'(16));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
